// File: rtl/clk_diag_pkg.sv
// Shared constants for the CLK diagnostic sequencer: function codes, FSM states, sequence length.
// CLK_AUTO_START_EN appends FUNC_START as the final master-reset step.
package clk_diag_pkg;

    localparam logic [6:0] FUNC_STOP_CLOCK    = 7'o000;
    localparam logic [6:0] FUNC_START         = 7'o001;
    localparam logic [6:0] FUNC_CLR_RESET     = 7'o006;
    localparam logic [6:0] FUNC_SET_RESET     = 7'o007;
    localparam logic [6:0] FUNC_CLR_BURST_R   = 7'o042;
    localparam logic [6:0] FUNC_CLR_BURST_L   = 7'o043;
    localparam logic [6:0] FUNC_CLR_SRC_RATE  = 7'o044;
    localparam logic [6:0] FUNC_RESET_PARITY  = 7'o046;
    localparam logic [6:0] FUNC_CLR_CRAM_ADDR = 7'o051;
    localparam logic [6:0] FUNC_EN_KL_OPCODES = 7'o067;
    localparam logic [6:0] FUNC_EBUS_LOAD     = 7'o076;

`ifdef CLK_AUTO_START_EN
    localparam logic [3:0] SEQ_LAST = 4'd10;
`else
    localparam logic [3:0] SEQ_LAST = 4'd9;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_HOLD,
        ST_SETTLE,
        ST_STEP
    } state_e;

endpackage

// File: rtl/clk_diag_sequencer_if.sv
// Request/handshake bundle between console logic (master) and the diag sequencer (slave).
interface clk_diag_sequencer_if #(
    parameter int DATA_W = 36
);
    logic              reqValid;
    logic [6:0]        reqFunc;
    logic [DATA_W-1:0] reqData;
    logic              reqMasterReset;
    logic              reqReady;
    logic              done;

    // A request (reqValid or reqMasterReset) is taken only on a clk edge where reqReady=1;
    // requests while reqReady=0 are dropped, and done pulses one clk when the work finishes.
    modport master (
        output reqValid, reqFunc, reqData, reqMasterReset,
        input  reqReady, done
    );

    modport slave (
        input  reqValid, reqFunc, reqData, reqMasterReset,
        output reqReady, done
    );
endinterface

// File: rtl/clk_diag_rom.sv
// Master-reset sequence table: step index to diag function code.
// CLK_AUTO_START_EN adds FUNC_START at index 10.
module clk_diag_rom
    import clk_diag_pkg::*;
(
    input  logic [3:0] idx,
    output logic [6:0] func
);

    always_comb begin
        func = FUNC_STOP_CLOCK;
        case (idx)
            4'd0:    func = FUNC_SET_RESET;
            4'd1:    func = FUNC_CLR_RESET;
            4'd2:    func = FUNC_STOP_CLOCK;
            4'd3:    func = FUNC_CLR_SRC_RATE;
            4'd4:    func = FUNC_RESET_PARITY;
            4'd5:    func = FUNC_CLR_BURST_R;
            4'd6:    func = FUNC_CLR_BURST_L;
            4'd7:    func = FUNC_CLR_CRAM_ADDR;
            4'd8:    func = FUNC_EN_KL_OPCODES;
            4'd9:    func = FUNC_EBUS_LOAD;
`ifdef CLK_AUTO_START_EN
            4'd10:   func = FUNC_START;
`endif
            default: func = FUNC_STOP_CLOCK;
        endcase
    end

endmodule

// File: rtl/clk_diag_sequencer.sv
// Drives EBUS diag functions (single request or master-reset sequence) paced by MHZ16_FREE edges.
// Optional CLK_AUTO_START_EN extends the sequence with FUNC_START.
module clk_diag_sequencer
    import clk_diag_pkg::*;
#(
    parameter int HOLD_EDGES   = 3,
    parameter int SETTLE_EDGES = 4,
    parameter int DATA_W       = 36
)
(
    input  logic                  clk,
    input  logic                  CROBAR,
    input  logic                  mhz16Free,
    clk_diag_sequencer_if.slave   req_if,
    output logic [6:0]            ebusDs,
    output logic                  ebusDiagStrobe,
    output logic [DATA_W-1:0]     ebusData,
    output logic [3:0]            seqIndex,
    output state_e                dbgState
);

    state_e            state_q, state_d;
    logic              m1_q;
    logic              seq_mode_q, seq_mode_d;
    logic [3:0]        seq_index_q, seq_index_d;
    logic [6:0]        func_q, func_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        hold_cnt_q, hold_cnt_d;
    logic [7:0]        set_cnt_q, set_cnt_d;
    logic [6:0]        ds_q, ds_d;
    logic              strobe_q, strobe_d;
    logic [DATA_W-1:0] bus_data_q, bus_data_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              fall, rise;
    logic [6:0]        rom_func;

    clk_diag_rom u_rom (
        .idx  (seq_index_q),
        .func (rom_func)
    );

    assign fall = m1_q & ~mhz16Free;
    assign rise = ~m1_q & mhz16Free;

    always_comb begin
        state_d     = state_q;
        seq_mode_d  = seq_mode_q;
        seq_index_d = seq_index_q;
        func_d      = func_q;
        data_d      = data_q;
        hold_cnt_d  = hold_cnt_q;
        set_cnt_d   = set_cnt_q;
        ds_d        = ds_q;
        strobe_d    = strobe_q;
        bus_data_d  = bus_data_q;
        ready_d     = ready_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Master reset wins over a simultaneous single request.
                if (req_if.reqMasterReset) begin
                    seq_mode_d  = 1'b1;
                    seq_index_d = 4'd0;
                    ready_d     = 1'b0;
                    state_d     = ST_ARM;
                end else if (req_if.reqValid) begin
                    seq_mode_d = 1'b0;
                    func_d     = req_if.reqFunc;
                    data_d     = req_if.reqData;
                    ready_d    = 1'b0;
                    state_d    = ST_ARM;
                end
            end
            ST_ARM: begin
                if (fall) begin
                    ds_d       = seq_mode_q ? rom_func : func_q;
                    bus_data_d = seq_mode_q ? '0 : data_q;
                    strobe_d   = 1'b1;
                    hold_cnt_d = 8'd0;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (fall) begin
                    if (hold_cnt_q == 8'(HOLD_EDGES - 1)) begin
                        strobe_d   = 1'b0;
                        ds_d       = 7'd0;
                        bus_data_d = '0;
                        set_cnt_d  = 8'd0;
                        state_d    = ST_SETTLE;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end
            end
            ST_SETTLE: begin
                if (rise) begin
                    set_cnt_d = set_cnt_q + 8'd1;
                    if (set_cnt_q == 8'(SETTLE_EDGES - 1)) begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_STEP: begin
                if (seq_mode_q && (seq_index_q < SEQ_LAST)) begin
                    seq_index_d = seq_index_q + 4'd1;
                    state_d     = ST_ARM;
                end else begin
                    done_d      = 1'b1;
                    ready_d     = 1'b1;
                    seq_index_d = 4'd0;
                    seq_mode_d  = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            state_q     <= ST_IDLE;
            m1_q        <= 1'b0;
            seq_mode_q  <= 1'b0;
            seq_index_q <= 4'd0;
            func_q      <= 7'd0;
            data_q      <= '0;
            hold_cnt_q  <= 8'd0;
            set_cnt_q   <= 8'd0;
            ds_q        <= 7'd0;
            strobe_q    <= 1'b0;
            bus_data_q  <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            m1_q        <= mhz16Free;
            seq_mode_q  <= seq_mode_d;
            seq_index_q <= seq_index_d;
            func_q      <= func_d;
            data_q      <= data_d;
            hold_cnt_q  <= hold_cnt_d;
            set_cnt_q   <= set_cnt_d;
            ds_q        <= ds_d;
            strobe_q    <= strobe_d;
            bus_data_q  <= bus_data_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    assign ebusDs          = ds_q;
    assign ebusDiagStrobe  = strobe_q;
    assign ebusData        = bus_data_q;
    assign seqIndex        = seq_index_q;
    assign dbgState        = state_q;
    assign req_if.reqReady = ready_q;
    assign req_if.done     = done_q;

endmodule

// File: doc/clk_diag_sequencer.md
Name: clk_diag_sequencer

Overview:
Hardware front-end sequencer for CLK diagnostic functions over the EBUS diag lines (ds, diagStrobe, data).
- Issues one function on request, or plays the fixed master-reset sequence.
- Paces every strobe against the free-running 16 MHz clock (MHZ16_FREE), so CLK board timing matches the PARSER-style front end.
- Sits between the console/bring-up logic and the EBOX EBUS diag inputs. It replaces ad-hoc poking of those lines.

Parameters:
- HOLD_EDGES, 3: additional MHZ16_FREE falling edges diagStrobe stays high after the assert edge.
- SETTLE_EDGES, 4: MHZ16_FREE rising edges after deassert before the next function may start.
- DATA_W, 36: EBUS data width.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- CROBAR, input, 1: asynchronous active-high reset.
- mhz16Free, input, 1: MHZ16_FREE level, synchronous to clk.
- reqValid, input, 1: single-function request; accepted when reqReady=1.
- reqFunc, input, 7: diag function code ds[0:6] (octal 000–177).
- reqData, input, DATA_W: EBUS data driven with a single function.
- reqMasterReset, input, 1: start master-reset sequence; accepted when reqReady=1.
- reqReady, output, 1: sequencer idle.
- done, output, 1: one-clk pulse when a single function or the whole sequence completes.
- ebusDs, output, 7: EBUS ds[0:6].
- ebusDiagStrobe, output, 1: EBUS diagStrobe.
- ebusData, output, DATA_W: EBUS data.
- seqIndex, output, 4: current sequence step (debug).

Behaviour:
- Reset values (async on CROBAR): ebusDs=0, ebusDiagStrobe=0, ebusData=0, reqReady=1, done=0, seqIndex=0, state=IDLE, counters 0.
- Edge detection:
  - m1 is the previous-cycle sample of mhz16Free.
  - fall = m1 & ~mhz16Free; rise = ~m1 & mhz16Free.
  - Registered outputs change on the clk edge at which fall/rise is true.
- IDLE:
  - If reqMasterReset=1: latch seq mode, seqIndex=0 → ARM. reqMasterReset beats reqValid when both are high.
  - Else if reqValid=1: latch reqFunc/reqData → ARM.
  - reqReady drops the cycle after acceptance.
- ARM: on fall, drive ebusDs=func, ebusData=data, ebusDiagStrobe=1, holdCnt=0 → HOLD.
- HOLD:
  - On each fall, holdCnt++.
  - On the fall where holdCnt==HOLD_EDGES-1: ebusDiagStrobe=0, ebusDs=0, ebusData=0, setCnt=0 → SETTLE.
  - Net effect: the strobe spans HOLD_EDGES full MHZ16 periods.
- SETTLE: on each rise, setCnt++; when setCnt reaches SETTLE_EDGES → STEP.
- STEP (one clk):
  - Seq mode and seqIndex<last: seqIndex++ → ARM.
  - Otherwise: done=1 for one clk, reqReady=1, seqIndex=0 → IDLE.
- Master-reset sequence, octal, in order, data always 0: 007 SET_RESET, 006 CLR_RESET, 000 stop clock, 044 clear source/rate, 046 reset parity regs, 042 clear burst right, 043 clear burst left, 051 clear CRAM diag addr, 067 enable KL opcodes, 076 EBUS load. Last index is 9.
- Requests seen while reqReady=0 are ignored, not queued.
- If mhz16Free is stuck, the block waits indefinitely. There is no timeout.
- CROBAR mid-operation: strobe drops immediately and asynchronously; the sequence is abandoned with no done pulse.
- All functions are full 7-bit codes. There is no truncation of ds.

Optional Feature:
CLK_AUTO_START_EN.
- Defined: the sequence gains index 10 = 001 (FUNC_START); last index becomes 10. done fires after the START settle.
- Undefined: the sequence ends at index 9; START must be issued as a single request.

Decomposition:
- Package clk_diag_pkg holds:
  - function code localparams (FUNC_START=7'o001, FUNC_SET_RESET=7'o007, FUNC_CLR_RESET=7'o006, etc.);
  - the state enum;
  - the sequence-length constant (conditional on CLK_AUTO_START_EN).
- One sub-module, clk_diag_rom: a combinational index→function-code table, so the sequence can be edited separately.

Test Plan:
1. Single reqFunc=7'o044, reqData=36'o123 → ebusDiagStrobe high from the first mhz16Free fall after accept, for exactly 3 MHZ16 periods. ebusDs=7'o044 and ebusData=36'o123 while the strobe is high, both 0 after. done pulses once, 4 rises after deassert.
2. reqMasterReset → ten strobes with ebusDs 007,006,000,044,046,042,043,051,067,076 in order. Strobe low ≥4 MHZ16 rises between strobes. Single done after the 076 settle. seqIndex tracks 0..9.
3. reqValid and reqMasterReset asserted in the same cycle → sequence runs; first ebusDs=7'o007. reqValid pulses during busy → no extra strobes.
4. Assert CROBAR during the HOLD of step 4 → ebusDiagStrobe=0, ebusDs=0 within the same cycle with no clk edge. After release, reqReady=1, seqIndex=0, no done.
5. Hold mhz16Free constant for 1000 clks after accept → no strobe, reqReady stays 0. Resume toggling → normal completion.
6. With CLK_AUTO_START_EN defined → eleventh strobe has ebusDs=7'o001, then done. Undefined → ten strobes only.
